// File: rtl/bus_status_pkg.sv
// Shared status encodings, controller states and cycle types for the 8288-style bus controller.
package bus_status_pkg;

   localparam logic [2:0] ST_INTA    = 3'b000;
   localparam logic [2:0] ST_IOR     = 3'b001;
   localparam logic [2:0] ST_IOW     = 3'b010;
   localparam logic [2:0] ST_HALT    = 3'b011;
   localparam logic [2:0] ST_FETCH   = 3'b100;
   localparam logic [2:0] ST_MEMR    = 3'b101;
   localparam logic [2:0] ST_MEMW    = 3'b110;
   localparam logic [2:0] ST_PASSIVE = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_T1,
      S_CMD,
      S_HALT_WAIT
   } bus_state_t;

   typedef enum logic [2:0] {
      CYC_INTA,
      CYC_IOR,
      CYC_IOW,
      CYC_HALT,
      CYC_FETCH,
      CYC_MEMR,
      CYC_MEMW,
      CYC_PASSIVE
   } cyc_t;

endpackage

// File: rtl/bus_status_decode.sv
// Combinational decode of the CPU status lines into a cycle type and direction/space flags.
module bus_status_decode
   import bus_status_pkg::*;
(
   input  logic [2:0] s_n,
   output cyc_t       cyc,
   output logic       is_read,
   output logic       is_write,
   output logic       is_io,
   output logic       is_passive
);

   always_comb begin
      cyc        = CYC_PASSIVE;
      is_read    = 1'b0;
      is_write   = 1'b0;
      is_io      = 1'b0;
      is_passive = 1'b0;
      case (s_n)
         ST_INTA:  begin cyc = CYC_INTA;  is_read  = 1'b1; end
         ST_IOR:   begin cyc = CYC_IOR;   is_read  = 1'b1; is_io = 1'b1; end
         ST_IOW:   begin cyc = CYC_IOW;   is_write = 1'b1; is_io = 1'b1; end
         ST_HALT:  begin cyc = CYC_HALT; end
         ST_FETCH: begin cyc = CYC_FETCH; is_read  = 1'b1; end
         ST_MEMR:  begin cyc = CYC_MEMR;  is_read  = 1'b1; end
         ST_MEMW:  begin cyc = CYC_MEMW;  is_write = 1'b1; end
         default:  begin cyc = CYC_PASSIVE; is_passive = 1'b1; end
      endcase
   end

endmodule

// File: rtl/bus_ctrl_8288.sv
// Max-mode bus controller: tracks T-states from s_n and drives ALE, transceiver controls
// and the active-low command strobes.
//
//  state       | meaning
//  S_IDLE      | bus passive, waiting for an active status sample
//  S_T1        | ALE pulse clock, cycle type latched
//  S_CMD       | command strobe and den asserted until passive is sampled
//  S_HALT_WAIT | halt acknowledged, no command, waiting for passive
module bus_ctrl_8288
   import bus_status_pkg::*;
#(
   parameter int WR_DELAY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] s_n,
   input  logic       aen_n,
   input  logic       cen,
   output logic       ale,
   output logic       den,
   output logic       dt_r_n,
   output logic       mrdc_n,
   output logic       mwtc_n,
   output logic       amwc_n,
   output logic       iorc_n,
   output logic       iowc_n,
   output logic       aiowc_n,
   output logic       inta_n
);

   localparam logic [1:0] WR_CNT_INIT = 2'(WR_DELAY);

   cyc_t       dec_cyc;
   logic       dec_read, dec_write, dec_io, dec_passive;

   bus_status_decode u_decode (
      .s_n        (s_n),
      .cyc        (dec_cyc),
      .is_read    (dec_read),
      .is_write   (dec_write),
      .is_io      (dec_io),
      .is_passive (dec_passive)
   );

   bus_state_t state;
   cyc_t       cyc_q;
   logic       wr_q, io_q, den_q;
   logic [1:0] wr_cnt;
   logic       mrdc_q, mwtc_q, amwc_q, iorc_q, iowc_q, aiowc_q, inta_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cyc_q   <= CYC_PASSIVE;
         wr_q    <= 1'b0;
         io_q    <= 1'b0;
         wr_cnt  <= 2'd0;
         ale     <= 1'b0;
         den_q   <= 1'b0;
         dt_r_n  <= 1'b1;
         mrdc_q  <= 1'b1;
         mwtc_q  <= 1'b1;
         amwc_q  <= 1'b1;
         iorc_q  <= 1'b1;
         iowc_q  <= 1'b1;
         aiowc_q <= 1'b1;
         inta_q  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (!dec_passive) begin
                  state  <= S_T1;
                  cyc_q  <= dec_cyc;
                  wr_q   <= dec_write;
                  io_q   <= dec_io;
                  ale    <= 1'b1;
                  dt_r_n <= ~dec_read;
               end
            end
            S_T1: begin
               ale <= 1'b0;
               if (cyc_q == CYC_HALT) begin
                  state <= S_HALT_WAIT;
               end else begin
                  state <= S_CMD;
                  den_q <= 1'b1;
                  if (wr_q) begin
                     wr_cnt <= WR_CNT_INIT;
                     if (io_q) aiowc_q <= 1'b0;
                     else      amwc_q  <= 1'b0;
                     // Zero delay: normal write goes low alongside the advanced strobe.
                     if (WR_DELAY == 0) begin
                        if (io_q) iowc_q <= 1'b0;
                        else      mwtc_q <= 1'b0;
                     end
                  end else begin
                     case (cyc_q)
                        CYC_IOR:  iorc_q <= 1'b0;
                        CYC_INTA: inta_q <= 1'b0;
                        default:  mrdc_q <= 1'b0;
                     endcase
                  end
               end
            end
            S_CMD: begin
               if (dec_passive) begin
                  state   <= S_IDLE;
                  wr_cnt  <= 2'd0;
                  den_q   <= 1'b0;
                  dt_r_n  <= 1'b1;
                  mrdc_q  <= 1'b1;
                  mwtc_q  <= 1'b1;
                  amwc_q  <= 1'b1;
                  iorc_q  <= 1'b1;
                  iowc_q  <= 1'b1;
                  aiowc_q <= 1'b1;
                  inta_q  <= 1'b1;
               end else if (wr_cnt != 2'd0) begin
                  wr_cnt <= wr_cnt - 2'd1;
                  if (wr_cnt == 2'd1) begin
                     if (io_q) iowc_q <= 1'b0;
                     else      mwtc_q <= 1'b0;
                  end
               end
            end
            S_HALT_WAIT: begin
               if (dec_passive) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Gating acts on the registered strobes only; the FSM is never held off.
   logic cmd_off;
   assign cmd_off = aen_n | ~cen;

   assign den     = den_q & cen;
   assign mrdc_n  = mrdc_q  | cmd_off;
   assign mwtc_n  = mwtc_q  | cmd_off;
   assign amwc_n  = amwc_q  | cmd_off;
   assign iorc_n  = iorc_q  | cmd_off;
   assign iowc_n  = iowc_q  | cmd_off;
   assign aiowc_n = aiowc_q | cmd_off;
   assign inta_n  = inta_q  | cmd_off;

endmodule

// File: tb/tb_bus_ctrl_8288.sv
// Directed scoreboard bench for bus_ctrl_8288 with three write-delay settings side by side.
module tb_bus_ctrl_8288;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] s_n;
   logic       aen_n;
   logic       cen;

   // {ale, den, dt_r_n, mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n}
   logic [9:0] o0, o1, o3;

   localparam logic [6:0] M_MRDC  = 7'b1000000;
   localparam logic [6:0] M_MWTC  = 7'b0100000;
   localparam logic [6:0] M_AMWC  = 7'b0010000;
   localparam logic [6:0] M_IORC  = 7'b0001000;
   localparam logic [6:0] M_IOWC  = 7'b0000100;
   localparam logic [6:0] M_AIOWC = 7'b0000010;
   localparam logic [6:0] M_INTA  = 7'b0000001;
   localparam logic [6:0] M_NONE  = 7'b0000000;

   typedef struct {
      string      tag;
      logic [9:0] e0;
      logic [9:0] e1;
      logic [9:0] e3;
   } exp_t;

   exp_t q[$];
   int   n_asserts = 0;
   int   n_fail    = 0;

   always #5 clk = ~clk;

   bus_ctrl_8288 #(.WR_DELAY(0)) dut0 (
      .clk(clk), .reset(reset), .s_n(s_n), .aen_n(aen_n), .cen(cen),
      .ale(o0[9]), .den(o0[8]), .dt_r_n(o0[7]), .mrdc_n(o0[6]), .mwtc_n(o0[5]),
      .amwc_n(o0[4]), .iorc_n(o0[3]), .iowc_n(o0[2]), .aiowc_n(o0[1]), .inta_n(o0[0]));

   bus_ctrl_8288 #(.WR_DELAY(1)) dut1 (
      .clk(clk), .reset(reset), .s_n(s_n), .aen_n(aen_n), .cen(cen),
      .ale(o1[9]), .den(o1[8]), .dt_r_n(o1[7]), .mrdc_n(o1[6]), .mwtc_n(o1[5]),
      .amwc_n(o1[4]), .iorc_n(o1[3]), .iowc_n(o1[2]), .aiowc_n(o1[1]), .inta_n(o1[0]));

   bus_ctrl_8288 #(.WR_DELAY(3)) dut3 (
      .clk(clk), .reset(reset), .s_n(s_n), .aen_n(aen_n), .cen(cen),
      .ale(o3[9]), .den(o3[8]), .dt_r_n(o3[7]), .mrdc_n(o3[6]), .mwtc_n(o3[5]),
      .amwc_n(o3[4]), .iorc_n(o3[3]), .iowc_n(o3[2]), .aiowc_n(o3[1]), .inta_n(o3[0]));

   function automatic logic [9:0] ev(input logic a, input logic d, input logic t,
                                     input logic [6:0] low);
      return {a, d, t, ~low};
   endfunction

   task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                       input logic [9:0] e3);
      exp_t e;
      e.tag = tag; e.e0 = e0; e.e1 = e1; e.e3 = e3;
      q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (q.size() == 0) begin
         n_asserts++;
         n_fail++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e = q.pop_front();
         check({e.tag, "/d0"}, o0, e.e0);
         check({e.tag, "/d1"}, o1, e.e1);
         check({e.tag, "/d3"}, o3, e.e3);
      end
   endtask

   task automatic step(input string tag, input logic [2:0] s, input logic a, input logic c,
                       input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e3);
      s_n = s; aen_n = a; cen = c;
      push(tag, e0, e1, e3);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic step_all(input string tag, input logic [2:0] s, input logic a,
                           input logic c, input logic [9:0] e);
      step(tag, s, a, c, e, e, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] idle_v;
      idle_v = ev(1'b0, 1'b0, 1'b1, M_NONE);

      reset = 1'b1; s_n = 3'b111; aen_n = 1'b0; cen = 1'b1;
      #12;
      push("reset", idle_v, idle_v, idle_v);
      pop_check();
      reset = 1'b0;

      step_all("idle_passive", 3'b111, 0, 1, idle_v);

      // Memory read
      step_all("memr_t1",   3'b101, 0, 1, ev(1, 0, 0, M_NONE));
      step_all("memr_cmd1", 3'b101, 0, 1, ev(0, 1, 0, M_MRDC));
      step_all("memr_cmd2", 3'b101, 0, 1, ev(0, 1, 0, M_MRDC));
      step_all("memr_cmd3", 3'b101, 0, 1, ev(0, 1, 0, M_MRDC));
      step_all("memr_end",  3'b111, 0, 1, idle_v);

      // Memory write, delayed normal strobe per instance
      step_all("memw_t1", 3'b110, 0, 1, ev(1, 0, 1, M_NONE));
      step("memw_cmd1", 3'b110, 0, 1, ev(0, 1, 1, M_AMWC | M_MWTC),
           ev(0, 1, 1, M_AMWC), ev(0, 1, 1, M_AMWC));
      step("memw_cmd2", 3'b110, 0, 1, ev(0, 1, 1, M_AMWC | M_MWTC),
           ev(0, 1, 1, M_AMWC | M_MWTC), ev(0, 1, 1, M_AMWC));
      step("memw_cmd3", 3'b110, 0, 1, ev(0, 1, 1, M_AMWC | M_MWTC),
           ev(0, 1, 1, M_AMWC | M_MWTC), ev(0, 1, 1, M_AMWC));
      step_all("memw_end", 3'b111, 0, 1, idle_v);

      // I/O write, passive arrives before the 3-clock delay elapses
      step_all("iow_t1", 3'b010, 0, 1, ev(1, 0, 1, M_NONE));
      step("iow_cmd1", 3'b010, 0, 1, ev(0, 1, 1, M_AIOWC | M_IOWC),
           ev(0, 1, 1, M_AIOWC), ev(0, 1, 1, M_AIOWC));
      step("iow_cmd2", 3'b010, 0, 1, ev(0, 1, 1, M_AIOWC | M_IOWC),
           ev(0, 1, 1, M_AIOWC | M_IOWC), ev(0, 1, 1, M_AIOWC));
      step_all("iow_end", 3'b111, 0, 1, idle_v);

      // Long I/O write: 3-clock delay reaches its terminal count
      step_all("iowl_t1", 3'b010, 0, 1, ev(1, 0, 1, M_NONE));
      step("iowl_cmd1", 3'b010, 0, 1, ev(0, 1, 1, M_AIOWC | M_IOWC),
           ev(0, 1, 1, M_AIOWC), ev(0, 1, 1, M_AIOWC));
      step("iowl_cmd2", 3'b010, 0, 1, ev(0, 1, 1, M_AIOWC | M_IOWC),
           ev(0, 1, 1, M_AIOWC | M_IOWC), ev(0, 1, 1, M_AIOWC));
      step("iowl_cmd3", 3'b010, 0, 1, ev(0, 1, 1, M_AIOWC | M_IOWC),
           ev(0, 1, 1, M_AIOWC | M_IOWC), ev(0, 1, 1, M_AIOWC));
      step_all("iowl_cmd4", 3'b010, 0, 1, ev(0, 1, 1, M_AIOWC | M_IOWC));
      step_all("iowl_end",  3'b111, 0, 1, idle_v);

      // I/O read with aen_n gating, then an ignored status change
      step_all("ior_t1",     3'b001, 0, 1, ev(1, 0, 0, M_NONE));
      step_all("ior_aen",    3'b001, 1, 1, ev(0, 1, 0, M_NONE));
      step_all("ior_change", 3'b101, 0, 1, ev(0, 1, 0, M_IORC));
      step_all("ior_end",    3'b111, 0, 1, idle_v);

      // Halt: ale only, then the controller must accept a new cycle
      step_all("halt_t1",   3'b011, 0, 1, ev(1, 0, 1, M_NONE));
      step_all("halt_wait", 3'b011, 0, 1, ev(0, 0, 1, M_NONE));
      step_all("halt_hold", 3'b011, 0, 1, ev(0, 0, 1, M_NONE));
      step_all("halt_end",  3'b111, 0, 1, idle_v);

      // INTA with cen low: ale still pulses, den and inta_n held off
      step_all("inta_t1",  3'b000, 0, 0, ev(1, 0, 0, M_NONE));
      step_all("inta_cen", 3'b000, 0, 0, ev(0, 0, 0, M_NONE));
      step_all("inta_on",  3'b000, 0, 1, ev(0, 1, 0, M_INTA));
      step_all("inta_end", 3'b111, 0, 1, idle_v);

      // Fetch followed back-to-back by MEMR after a single passive sample
      step_all("fetch_t1",  3'b100, 0, 1, ev(1, 0, 0, M_NONE));
      step_all("fetch_cmd", 3'b100, 0, 1, ev(0, 1, 0, M_MRDC));
      step_all("fetch_end", 3'b111, 0, 1, idle_v);

      // Reset asserted in CMD of a memory read
      step_all("rst_t1",  3'b101, 0, 1, ev(1, 0, 0, M_NONE));
      step_all("rst_cmd", 3'b101, 0, 1, ev(0, 1, 0, M_MRDC));
      #2;
      reset = 1'b1;
      #1;
      push("rst_async", idle_v, idle_v, idle_v);
      pop_check();
      @(negedge clk);
      reset = 1'b0;
      step_all("rst_restart_t1", 3'b101, 0, 1, ev(1, 0, 0, M_NONE));
      step_all("rst_restart_cmd", 3'b101, 0, 1, ev(0, 1, 0, M_MRDC));
      step_all("rst_restart_end", 3'b111, 0, 1, idle_v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
